wb_irq_ctrl: RTL and testbench

//  Parametrised Wishbone B3 interrupt controller. Replaces the hard-wired per-bit

---
 rtl/wb_irq_ctrl.sv | 122 ++++++++++++
 tb/tb_wb_irq_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_irq_ctrl.sv
// Wishbone interrupt controller: synchronises raw sources, applies edge/level mode,
// polarity and mask, and exposes a status / W1C register file on the slave port.
module wb_irq_ctrl #(
    parameter int          NUM_IRQ     = 20,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] RESET_MASK  = 32'h0
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [31:0]        wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    input  logic [NUM_IRQ-1:0] irq_src_i,
    output logic [NUM_IRQ-1:0] irq_o,
    output logic               irq_any_o
);
    localparam logic [2:0] OFF_STATUS = 3'd0;
    localparam logic [2:0] OFF_MASK   = 3'd1;
    localparam logic [2:0] OFF_PEND   = 3'd2;
    localparam logic [2:0] OFF_MODE   = 3'd3;
    localparam logic [2:0] OFF_POL    = 3'd4;
    localparam logic [2:0] OFF_SWSET  = 3'd5;

    logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];
    logic [NUM_IRQ-1:0] r_hist, r_mask, r_mode, r_pol, r_pend;
    logic               r_ack, r_err;
    logic [31:0]        r_dat;

    logic [31:0]        w_be;
    logic [NUM_IRQ-1:0] w_be_n, w_wd, w_s, w_edge, w_clr, w_arm;
    logic [NUM_IRQ-1:0] w_mask_next, w_mode_next, w_pol_next, w_pend_next, w_rd_n;
    logic [2:0]         w_off;
    logic               w_req, w_map, w_wr;

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_be
        assign w_be[gi*8 +: 8] = {8{wb_sel_i[gi]}};
    end

    if (NUM_IRQ < 32) begin : g_unused_hi
        logic w_unused_hi;
        assign w_unused_hi = ^{wb_dat_i[31:NUM_IRQ], w_be[31:NUM_IRQ]};
    end
    logic w_unused_adr;
    assign w_unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

    assign w_off  = wb_adr_i[4:2];
    assign w_req  = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
    assign w_map  = ~(w_off[2] & w_off[1]);
    assign w_wr   = w_req & wb_we_i & w_map;
    assign w_be_n = w_be[NUM_IRQ-1:0];
    assign w_wd   = wb_dat_i[NUM_IRQ-1:0] & w_be_n;
    assign w_s    = r_sync[SYNC_STAGES-1];

    assign w_mask_next = (w_wr && w_off == OFF_MASK) ? ((r_mask & ~w_be_n) | w_wd) : r_mask;
    assign w_mode_next = (w_wr && w_off == OFF_MODE) ? ((r_mode & ~w_be_n) | w_wd) : r_mode;
    assign w_pol_next  = (w_wr && w_off == OFF_POL)  ? ((r_pol  & ~w_be_n) | w_wd) : r_pol;

    // Edge detection runs on the raw synchronised history, so polarity/mode writes never fake an edge.
    assign w_edge = (~r_pol & w_s & ~r_hist) | (r_pol & ~w_s & r_hist)
                  | ((w_wr && w_off == OFF_SWSET) ? w_wd : '0);
    assign w_clr  = (w_wr && w_off == OFF_PEND) ? w_wd : '0;
    assign w_arm  = w_mode_next & ~r_mode;

    assign w_pend_next = ((r_mode & ((r_pend & ~w_clr) | w_edge))
                        | (~r_mode & (w_s ^ r_pol))) & ~w_arm;

    always_comb begin
        w_rd_n = '0;
        case (w_off)
            OFF_STATUS: w_rd_n = r_pend & r_mask;
            OFF_MASK:   w_rd_n = r_mask;
            OFF_PEND:   w_rd_n = r_pend;
            OFF_MODE:   w_rd_n = r_mode;
            OFF_POL:    w_rd_n = r_pol;
            default:    w_rd_n = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_hist <= '0;
            r_mask <= RESET_MASK[NUM_IRQ-1:0];
            r_mode <= '0;
            r_pol  <= '0;
            r_pend <= '0;
        end else begin
            r_sync[0] <= irq_src_i;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_hist <= w_s;
            r_mask <= w_mask_next;
            r_mode <= w_mode_next;
            r_pol  <= w_pol_next;
            r_pend <= w_pend_next;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req & w_map;
            r_err <= w_req & ~w_map;
            if (w_req) r_dat <= wb_we_i ? 32'h0 : 32'(w_rd_n);
        end
    end

    assign wb_ack_o  = r_ack;
    assign wb_err_o  = r_err;
    assign wb_dat_o  = r_dat;
    assign irq_o     = r_pend & r_mask;
    assign irq_any_o = |irq_o;
endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Bench for wb_irq_ctrl: directed scenarios plus random bus/source traffic,
// all checked against a word-level reference model of the register rules.
module tb_wb_irq_ctrl;
    localparam int N = 20;
    localparam int S = 2;

    logic          clk, rst;
    logic [31:0]   wb_adr, wb_dat;
    logic [3:0]    wb_sel;
    logic          wb_we, wb_cyc, wb_stb;
    logic [N-1:0]  src;
    logic [31:0]   dat_o;
    logic          ack_o, err_o, irq_any;
    logic [N-1:0]  irq_o;

    int n_cmp = 0;
    int n_fail = 0;

    wb_irq_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(S), .RESET_MASK(32'h0)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat),
        .wb_sel_i(wb_sel), .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
        .wb_dat_o(dat_o), .wb_ack_o(ack_o), .wb_err_o(err_o),
        .irq_src_i(src), .irq_o(irq_o), .irq_any_o(irq_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [N-1:0] m_mask, m_mode, m_pol, m_pend;
    logic [N-1:0] m_line [0:S];   // m_line[j]: source value sampled j+1 edges ago
    logic         m_ack, m_err, m_rd;
    logic [31:0]  m_dat;
    logic [N-1:0] n_mask, n_mode, n_pol, n_pend, mc_bytes, mc_s, mc_h, mc_det, m_irq;
    logic         n_ack, n_err, n_rd, mc_req, mc_mapped, mc_wr;
    logic [31:0]  n_dat;
    logic [2:0]   mc_off;

    function automatic logic [N-1:0] merge(input logic [N-1:0] old, input logic [31:0] d,
                                           input logic [3:0] sel);
        logic [31:0] t;
        t = 32'(old);
        for (int b = 0; b < 4; b++) if (sel[b]) t[b*8 +: 8] = d[b*8 +: 8];
        return t[N-1:0];
    endfunction

    assign m_irq = m_pend & m_mask;

    always_comb begin
        mc_req    = wb_cyc & wb_stb & ~m_ack & ~m_err;
        mc_off    = wb_adr[4:2];
        mc_mapped = (mc_off < 3'd6);
        mc_wr     = mc_req & wb_we & mc_mapped;
        mc_bytes  = merge('0, wb_dat, wb_sel);
        mc_s      = m_line[S-1];
        mc_h      = m_line[S];
        mc_det    = (mc_s & ~mc_h & ~m_pol) | (~mc_s & mc_h & m_pol);
        n_mask    = (mc_wr && mc_off == 3'd1) ? merge(m_mask, wb_dat, wb_sel) : m_mask;
        n_mode    = (mc_wr && mc_off == 3'd3) ? merge(m_mode, wb_dat, wb_sel) : m_mode;
        n_pol     = (mc_wr && mc_off == 3'd4) ? merge(m_pol,  wb_dat, wb_sel) : m_pol;
        n_ack     = mc_req & mc_mapped;
        n_err     = mc_req & ~mc_mapped;
        n_rd      = mc_req & ~wb_we & mc_mapped;
        n_dat     = 32'h0;
        case (mc_off)
            3'd0: n_dat = 32'(m_pend & m_mask);
            3'd1: n_dat = 32'(m_mask);
            3'd2: n_dat = 32'(m_pend);
            3'd3: n_dat = 32'(m_mode);
            3'd4: n_dat = 32'(m_pol);
            default: n_dat = 32'h0;
        endcase
        n_pend = m_pend;
        for (int i = 0; i < N; i++) begin
            if (mc_wr && mc_off == 3'd3 && n_mode[i] && !m_mode[i]) n_pend[i] = 1'b0;
            else if (!m_mode[i]) n_pend[i] = mc_s[i] ^ m_pol[i];
            else if (mc_det[i] || (mc_wr && mc_off == 3'd5 && mc_bytes[i])) n_pend[i] = 1'b1;
            else if (mc_wr && mc_off == 3'd2 && mc_bytes[i]) n_pend[i] = 1'b0;
            else n_pend[i] = m_pend[i];
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mask <= '0; m_mode <= '0; m_pol <= '0; m_pend <= '0;
            m_ack <= 1'b0; m_err <= 1'b0; m_rd <= 1'b0; m_dat <= '0;
            for (int i = 0; i <= S; i++) m_line[i] <= '0;
        end else begin
            m_mask <= n_mask; m_mode <= n_mode; m_pol <= n_pol; m_pend <= n_pend;
            m_ack <= n_ack; m_err <= n_err; m_rd <= n_rd; m_dat <= n_dat;
            m_line[0] <= src;
            for (int i = 1; i <= S; i++) m_line[i] <= m_line[i-1];
        end
    end

    // ---------------- continuous checker ----------------
    always @(negedge clk) begin
        n_cmp++;
        assert (irq_o === m_irq) else begin
            n_fail++; $error("FAIL irq_o obs=%h exp=%h", irq_o, m_irq);
        end
        n_cmp++;
        assert (irq_any === (|m_irq)) else begin
            n_fail++; $error("FAIL irq_any obs=%b exp=%b", irq_any, |m_irq);
        end
        n_cmp++;
        assert (ack_o === m_ack) else begin
            n_fail++; $error("FAIL ack obs=%b exp=%b", ack_o, m_ack);
        end
        n_cmp++;
        assert (err_o === m_err) else begin
            n_fail++; $error("FAIL err obs=%b exp=%b", err_o, m_err);
        end
        if (m_ack && m_rd) begin
            n_cmp++;
            assert (dat_o === m_dat) else begin
                n_fail++; $error("FAIL rdata obs=%h exp=%h", dat_o, m_dat);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++; $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [2:0] off, input logic [31:0] d,
                       input logic [3:0] sel, output logic [31:0] rd, output logic er);
        int k;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = w;
        wb_adr = {27'd0, off, 2'b00}; wb_dat = d; wb_sel = sel;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(ack_o || err_o) && k < 8);
        n_cmp++;
        assert (ack_o || err_o) else begin
            n_fail++; $error("FAIL bus_timeout off=%0d obs=none exp=ack_or_err", off);
        end
        rd = dat_o;
        er = err_o;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        $display("[tb] %s off=0x%02h wdata=%h sel=%b rdata=%h err=%b",
                 w ? "WR" : "RD", {off, 2'b00}, d, sel, rd, er);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    logic [31:0] rdv;
    logic        erv;

    initial begin
        rst = 1'b1; src = '0; wb_adr = '0; wb_dat = '0; wb_sel = '0;
        wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
        #1;
        chk("reset_irq", 32'(irq_o), 32'h0);
        chk("reset_ack", 32'(ack_o), 32'h0);
        chk("reset_err", 32'(err_o), 32'h0);
        chk("reset_dat", dat_o, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: level source with mask closed, then opened
        src[2] = 1'b1;
        repeat (5) @(negedge clk);
        bus(1'b0, 3'd0, 32'h0, 4'hF, rdv, erv); chk("t1_status", rdv, 32'h0);
        chk("t1_irq_masked", 32'(irq_o), 32'h0);
        bus(1'b0, 3'd2, 32'h0, 4'hF, rdv, erv); chk("t1_pending", rdv, 32'h4);
        bus(1'b1, 3'd1, 32'h4, 4'hF, rdv, erv);
        chk("t1_irq_after_mask", 32'(irq_o), 32'h4);
        src[2] = 1'b0;
        repeat (2) @(negedge clk);
        chk("t1_irq_2edges", 32'(irq_o[2]), 32'h1);
        @(negedge clk);
        chk("t1_irq_3edges", 32'(irq_o[2]), 32'h0);

        // 2: edge mode latches a pulse until W1C
        bus(1'b1, 3'd3, 32'h1, 4'hF, rdv, erv);
        bus(1'b1, 3'd1, 32'h1, 4'hF, rdv, erv);
        @(negedge clk); src[0] = 1'b1;
        repeat (3) @(negedge clk); src[0] = 1'b0;
        repeat (5) @(negedge clk);
        bus(1'b0, 3'd2, 32'h0, 4'hF, rdv, erv); chk("t2_pending_set", rdv, 32'h1);
        chk("t2_irq_set", 32'(irq_o), 32'h1);
        bus(1'b1, 3'd2, 32'h1, 4'hF, rdv, erv);
        bus(1'b0, 3'd2, 32'h0, 4'hF, rdv, erv); chk("t2_pending_clr", rdv, 32'h0);
        chk("t2_irq_clr", 32'(irq_o), 32'h0);

        // 3: W1C on the same edge as a detected rising edge
        src[0] = 1'b1;
        @(negedge clk);
        bus(1'b1, 3'd2, 32'h1, 4'hF, rdv, erv);
        bus(1'b0, 3'd2, 32'h0, 4'hF, rdv, erv); chk("t3_set_wins", rdv, 32'h1);
        src[0] = 1'b0;
        repeat (4) @(negedge clk);
        bus(1'b1, 3'd2, 32'h1, 4'hF, rdv, erv);

        // 4: falling-edge source
        bus(1'b1, 3'd4, 32'h8, 4'hF, rdv, erv);
        bus(1'b1, 3'd3, 32'h8, 4'hF, rdv, erv);
        bus(1'b0, 3'd2, 32'h0, 4'hF, rdv, erv); chk("t4_armed_clear", rdv, 32'h0);
        src[3] = 1'b1;
        repeat (5) @(negedge clk);
        bus(1'b0, 3'd2, 32'h0, 4'hF, rdv, erv); chk("t4_rise_ignored", rdv, 32'h0);
        src[3] = 1'b0;
        repeat (5) @(negedge clk);
        bus(1'b0, 3'd2, 32'h0, 4'hF, rdv, erv); chk("t4_fall_sets", rdv, 32'h8);
        bus(1'b1, 3'd2, 32'h8, 4'hF, rdv, erv);
        bus(1'b1, 3'd4, 32'h0, 4'hF, rdv, erv);
        bus(1'b0, 3'd2, 32'h0, 4'hF, rdv, erv); chk("t4_pol_write_no_set", rdv, 32'h0);

        // 5: unmapped offset, byte enables, width clipping
        bus(1'b0, 3'd6, 32'h0, 4'hF, rdv, erv);
        chk("t5_err", 32'(erv), 32'h1);
        chk("t5_no_ack", 32'(ack_o), 32'h0);
        @(negedge clk);
        chk("t5_err_one_cycle", 32'(err_o), 32'h0);
        bus(1'b1, 3'd1, 32'hFFFF_FFFF, 4'b0001, rdv, erv);
        bus(1'b0, 3'd1, 32'h0, 4'hF, rdv, erv); chk("t5_mask_byte0", rdv, 32'h0000_00FF);
        bus(1'b1, 3'd3, 32'hFFFF_FFFF, 4'hF, rdv, erv);
        bus(1'b0, 3'd3, 32'h0, 4'hF, rdv, erv); chk("t5_mode_width", rdv, 32'h000F_FFFF);
        bus(1'b1, 3'd3, 32'h0, 4'hF, rdv, erv);

        // 6: reset while a read is waiting for ack
        src[1] = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_irq_before", 32'(irq_o), 32'h2);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h4; wb_sel = 4'hF;
        #2 rst = 1'b1;
        #1;
        chk("t6_irq_in_reset", 32'(irq_o), 32'h0);
        chk("t6_ack_in_reset", 32'(ack_o), 32'h0);
        @(negedge clk);
        chk("t6_ack_held", 32'(ack_o), 32'h0);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        rst = 1'b0;
        bus(1'b0, 3'd1, 32'h0, 4'hF, rdv, erv); chk("t6_mask_reset", rdv, 32'h0);
        bus(1'b0, 3'd3, 32'h0, 4'hF, rdv, erv); chk("t6_mode_reset", rdv, 32'h0);
        bus(1'b0, 3'd4, 32'h0, 4'hF, rdv, erv); chk("t6_pol_reset", rdv, 32'h0);

        // random traffic: source toggles and arbitrary register accesses
        for (int it = 0; it < 120; it++) begin
            src = N'($urandom);
            bus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                4'($urandom), rdv, erv);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
